// File: rtl/rgbw_lamp_ctrl.sv
// rgbw_lamp_ctrl: SPI-fed RGBW dimmer with header/trailer-checked frames, luminance scaling and
// double-buffered 8-bit PWM outputs.
module rgbw_lamp_ctrl #(
  parameter int PWM_DIV = 4
) (
  input  logic clk12,
  input  logic reset,
  input  logic sck0,
  input  logic mosi,
  input  logic cs,
  output logic red_pin,
  output logic green_pin,
  output logic blue_pin,
  output logic white_pin,
  output logic dbg
);
  localparam int PW = PWM_DIV > 1 ? $clog2(PWM_DIV) : 1;
  // [0],[1] synchronizer stages, [2] history for edge detection
  logic [2:0] cs_q, sck_q, mosi_q;
  logic [7:0] sr_q;
  logic [2:0] bc_q, idx_q;
  logic bv_q, dbg_q;
  logic [7:0] lum_stg_q, lum_q, pc_q;
  logic [3:0][7:0] stg_q, lvl_q, buf_q, duty_d;
  logic [3:0] pin_q;
  logic [PW-1:0] pre_q;
  logic sample_d, step_d, wrap_d;
  always_ff @(posedge clk12 or negedge reset)
    if (!reset) begin
      cs_q   <= 3'b111;
      sck_q  <= 3'b000;
      mosi_q <= 3'b000;
    end else begin
      cs_q   <= {cs_q[1:0], cs};
      sck_q  <= {sck_q[1:0], sck0};
      mosi_q <= {mosi_q[1:0], mosi};
    end
  // a falling SCK still counts in the cycle CS rises, so a completed byte wins over the CS clear
  assign sample_d = sck_q[2] & ~sck_q[1] & ~(cs_q[1] & cs_q[2]);
  always_ff @(posedge clk12 or negedge reset)
    if (!reset) begin
      sr_q <= '0;
      bc_q <= '0;
      bv_q <= 1'b0;
    end else if (sample_d) begin
      sr_q <= {sr_q[6:0], mosi_q[2]};
      bc_q <= bc_q + 3'd1;
      bv_q <= bc_q == 3'd7;
    end else begin
      sr_q <= cs_q[1] ? '0 : sr_q;
      bc_q <= cs_q[1] ? '0 : bc_q;
      bv_q <= 1'b0;
    end
  always_ff @(posedge clk12 or negedge reset)
    if (!reset) begin
      idx_q     <= '0;
      lum_stg_q <= '0;
      lum_q     <= '0;
      stg_q     <= '0;
      lvl_q     <= '0;
      dbg_q     <= 1'b0;
    end else if (bv_q) begin
      idx_q <= ((idx_q == 3'd0 && sr_q != 8'h55) || idx_q == 3'd7) ? 3'd0 : idx_q + 3'd1;
      if (idx_q == 3'd1) lum_stg_q <= sr_q;
      if (idx_q >= 3'd2 && idx_q <= 3'd5) stg_q[idx_q[1:0] - 2'd2] <= sr_q;
      if (idx_q == 3'd7 && sr_q == 8'hA4) begin
        lum_q <= lum_stg_q;
        lvl_q <= stg_q;
        dbg_q <= ~dbg_q;
      end
    end
  always_comb
    for (int i = 0; i < 4; i++)
      duty_d[i] = 8'((16'(lvl_q[i]) * (16'(lum_q) + 16'd1)) >> 8);
  assign step_d = pre_q == PW'(PWM_DIV - 1);
  assign wrap_d = step_d && pc_q == 8'd254;
  // duties only change at the period boundary so no period is ever cut short
  always_ff @(posedge clk12 or negedge reset)
    if (!reset) begin
      pre_q <= '0;
      pc_q  <= '0;
      buf_q <= '0;
      pin_q <= '0;
    end else begin
      pre_q <= step_d ? '0 : pre_q + 1'b1;
      if (step_d) pc_q <= wrap_d ? 8'd0 : pc_q + 8'd1;
      if (wrap_d) buf_q <= duty_d;
      for (int i = 0; i < 4; i++) pin_q[i] <= pc_q < buf_q[i];
    end
  assign {white_pin, blue_pin, green_pin, red_pin} = pin_q;
  assign dbg = dbg_q;
endmodule

// File: tb/tb_rgbw_lamp_ctrl.sv
// tb_rgbw_lamp_ctrl: directed SPI frames against hand-computed PWM high counts and dbg toggles.
module tb_rgbw_lamp_ctrl;
  localparam int DIV = 4;
  localparam int PER = 255 * DIV;
  logic clk12 = 1'b0, reset = 1'b0, sck0 = 1'b0, mosi = 1'b0, cs = 1'b1;
  logic red_pin, green_pin, blue_pin, white_pin, dbg;
  int errs = 0, checks = 0, tog = 0;
  logic dprev = 1'b0;
  int r, g, b, w;

  rgbw_lamp_ctrl #(.PWM_DIV(DIV)) dut (
    .clk12(clk12), .reset(reset), .sck0(sck0), .mosi(mosi), .cs(cs),
    .red_pin(red_pin), .green_pin(green_pin), .blue_pin(blue_pin),
    .white_pin(white_pin), .dbg(dbg)
  );

  always #5 clk12 = ~clk12;

  always @(negedge clk12) begin
    if (reset && dbg !== dprev) tog++;
    dprev = dbg;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk12);
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sck0 = 1'b1;
      mosi = v[i];
      clks(3);
      sck0 = 1'b0;
      clks(3);
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    cs = 1'b0;
    clks(3);
    send_bits(v, 8);
    cs = 1'b1;
    clks(3);
  endtask

  task automatic send_frame(input logic [0:7][7:0] f, input bit one_cs);
    if (one_cs) begin
      cs = 1'b0;
      clks(3);
      for (int i = 0; i < 8; i++) send_bits(f[i], 8);
      cs = 1'b1;
      clks(3);
    end else
      for (int i = 0; i < 8; i++) send_byte(f[i]);
  endtask

  task automatic measure(output int rr, output int gg, output int bb, output int ww);
    rr = 0; gg = 0; bb = 0; ww = 0;
    for (int i = 0; i < PER; i++) begin
      @(negedge clk12);
      rr += int'(red_pin); gg += int'(green_pin); bb += int'(blue_pin); ww += int'(white_pin);
    end
  endtask

  task automatic settle_measure(input string tag, input int er, input int eg, input int eb, input int ew);
    clks(PER + 10);
    measure(r, g, b, w);
    check({tag, "_red"}, r, er);
    check({tag, "_green"}, g, eg);
    check({tag, "_blue"}, b, eb);
    check({tag, "_white"}, w, ew);
  endtask

  task automatic period_check(input string tag);
    int t;
    logic p;
    t = 0;
    do begin p = red_pin; @(negedge clk12); t++; end
    while (!(red_pin && !p) && t < 2 * PER);
    t = 0;
    do begin p = red_pin; @(negedge clk12); t++; end
    while (!(red_pin && !p) && t < 2 * PER);
    check(tag, t, PER);
  endtask

  initial begin
    clks(2);
    check("rst_pins", int'({red_pin, green_pin, blue_pin, white_pin}), 0);
    check("rst_dbg", int'(dbg), 0);
    clks(8);
    reset = 1'b1;
    clks(3);

    send_frame({8'h55, 8'hFF, 8'h24, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hA4}, 1'b0);
    check("first_dbg", int'(dbg), 1);
    check("first_tog", tog, 1);
    settle_measure("first", 36 * DIV, 0, PER, 0);

    for (int k = 0; k < 20; k++)
      send_frame({8'h55, 8'hFF, 8'h24, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hA4}, k[0]);
    check("repeat_tog", tog, 21);
    check("repeat_dbg", int'(dbg), 1);
    period_check("period_36");
    send_frame({8'h55, 8'hFF, 8'h23, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hA4}, 1'b1);
    check("r35_tog", tog, 22);
    settle_measure("r35", 35 * DIV, 0, PER, 0);
    period_check("period_35");

    send_byte(8'h54);
    send_byte(8'hFF);
    send_byte(8'h80);
    send_frame({8'h55, 8'h80, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h00, 8'hA4}, 1'b0);
    check("resync_tog", tog, 23);
    settle_measure("scale", 128 * DIV, 0, 0, 0);

    send_frame({8'h55, 8'hFF, 8'h10, 8'h10, 8'h10, 8'h10, 8'h00, 8'hA5}, 1'b0);
    check("badtrl_tog", tog, 23);
    check("badtrl_dbg", int'(dbg), 1);
    settle_measure("badtrl", 128 * DIV, 0, 0, 0);

    send_byte(8'h55);
    send_byte(8'hFF);
    cs = 1'b0;
    clks(3);
    send_bits(8'h77, 5);
    cs = 1'b1;
    clks(3);
    send_byte(8'h40);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h00);
    send_byte(8'hA4);
    check("partial_tog", tog, 24);
    check("partial_dbg", int'(dbg), 0);
    settle_measure("partial", 64 * DIV, 0, 0, PER);

    send_byte(8'h55);
    send_byte(8'hFF);
    send_byte(8'h80);
    send_byte(8'h80);
    reset = 1'b0;
    clks(2);
    check("abort_pins", int'({red_pin, green_pin, blue_pin, white_pin}), 0);
    check("abort_dbg", int'(dbg), 0);
    clks(8);
    reset = 1'b1;
    clks(3);
    send_frame({8'h55, 8'hFF, 8'h08, 8'h10, 8'h20, 8'h00, 8'h00, 8'hA4}, 1'b1);
    check("after_rst_dbg", int'(dbg), 1);
    check("after_rst_tog", tog, 25);
    settle_measure("after_rst", 8 * DIV, 16 * DIV, 32 * DIV, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
